core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I embedded softcore. It fetches an instruction over a simple req/ready handshake and latches it for the combinational instruction decoder. It then steps the instruction through decode, execute, optional memory access and writeback, driving register-file, PC and data-memory strobes. Unsupported opcode categories reported by the decoder are diverted to a trap state.

---
 rtl/core_sequencer_if.sv | 33 +++
 rtl/core_sequencer.sv | 127 ++++++++++++
 tb/tb_core_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - sequencer bus: fetch/data handshakes, decoder hooks, strobes
// master = sequencer side, slave = datapath/memory side.
interface core_sequencer_if;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        dec_illegal;
   logic        branch_taken;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready;
   logic        rf_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic        retired;
   logic        trap;
   logic [3:0]  trap_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   modport master (
      output imem_req, inst, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
             retired, trap, trap_cause, state, instret,
      input  imem_ready, imem_rdata, dec_illegal, branch_taken, dmem_ready
   );

   modport slave (
      input  imem_req, inst, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
             retired, trap, trap_cause, state, instret,
      output imem_ready, imem_rdata, dec_illegal, branch_taken, dmem_ready
   );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb/trap)
// Optional retired-instruction counter enabled by defining CORE_SEQ_INSTRET_EN.
module core_sequencer (
   input  logic             clk,
   input  logic             reset,
   core_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [4:0]  OPC_LOAD   = 5'b00000;
   localparam logic [4:0]  OPC_STORE  = 5'b01000;
   localparam logic [4:0]  OPC_OP     = 5'b01100;
   localparam logic [4:0]  OPC_OP_IMM = 5'b00100;
   localparam logic [4:0]  OPC_LUI    = 5'b01101;
   localparam logic [4:0]  OPC_AUIPC  = 5'b00101;
   localparam logic [4:0]  OPC_JAL    = 5'b11011;
   localparam logic [4:0]  OPC_JALR   = 5'b11001;
   localparam logic [4:0]  OPC_BRANCH = 5'b11000;
   localparam logic [31:0] INST_NOP   = 32'h00000013;

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;

   logic [4:0]  opc;
   logic        is_load, is_store, writes_rd, redirect;
   logic        imem_req, dmem_req, dmem_we, rf_we, pc_we, retired, trap;
   logic [1:0]  pc_sel;
   logic [3:0]  trap_cause;

   assign opc       = inst_q[6:2];
   assign is_load   = (opc == OPC_LOAD);
   assign is_store  = (opc == OPC_STORE);
   assign writes_rd = (inst_q[11:7] != 5'd0) &&
                      (opc == OPC_OP  || opc == OPC_OP_IMM || opc == OPC_LUI  ||
                       opc == OPC_AUIPC || opc == OPC_JAL  || opc == OPC_JALR ||
                       opc == OPC_LOAD);
   assign redirect  = (opc == OPC_JAL) || (opc == OPC_JALR) ||
                      ((opc == OPC_BRANCH) && bus.branch_taken);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         inst_q  <= INST_NOP;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
      end
   end

   // inst only changes on the accepting fetch edge, so it is stable DECODE..WB/TRAP.
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'd0;
      retired    = 1'b0;
      trap       = 1'b0;
      trap_cause = 4'd0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               inst_d  = bus.imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = (bus.dec_illegal || inst_q[1:0] != 2'b11) ? S_TRAP : S_EXEC;
         S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (bus.dmem_ready) state_d = S_WB;
         end
         S_WB: begin
            pc_we   = 1'b1;
            retired = 1'b1;
            rf_we   = writes_rd;
            pc_sel  = redirect ? 2'd1 : 2'd0;
            state_d = S_FETCH;
         end
         S_TRAP: begin
            pc_we      = 1'b1;
            pc_sel     = 2'd2;
            trap       = 1'b1;
            trap_cause = 4'd2;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign bus.imem_req   = imem_req;
   assign bus.inst       = inst_q;
   assign bus.dmem_req   = dmem_req;
   assign bus.dmem_we    = dmem_we;
   assign bus.rf_we      = rf_we;
   assign bus.pc_we      = pc_we;
   assign bus.pc_sel     = pc_sel;
   assign bus.retired    = retired;
   assign bus.trap       = trap;
   assign bus.trap_cause = trap_cause;
   assign bus.state      = state_q;

`ifdef CORE_SEQ_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk) begin
      if (reset)        instret_q <= 32'h0;
      else if (retired) instret_q <= instret_q + 32'd1;
   end

   assign bus.instret = instret_q;
`else
   assign bus.instret = 32'h0;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer
// Table vectors, reset corner sequences and random instructions against a phase-list model.
module tb_core_sequencer;
   logic clk = 1'b0;
   logic reset;
   core_sequencer_if bus();

   core_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_cnt  = 32'h0;

   localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;

   typedef struct {
      logic [31:0] w;
      bit          ill;
      bit          tk;
      int          iw;
      int          dw;
      int          cyc;
      logic [4:0]  fin;   // {rf_we, pc_sel, retired, trap} in the final WB/TRAP cycle
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit writes_rd(input logic [31:0] w);
      case (w[6:2])
         5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000:
            return w[11:7] != 5'd0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit redirects(input logic [31:0] w, input bit tk);
      return (w[6:2] == 5'b11011) || (w[6:2] == 5'b11001) || (w[6:2] == 5'b11000 && tk);
   endfunction

   function automatic logic [47:0] expect_vec(input int ph, input logic [31:0] w, input bit tk);
      logic [1:0]  psel;
      logic [31:0] cnt;
`ifdef CORE_SEQ_INSTRET_EN
      cnt = exp_cnt;
`else
      cnt = 32'h0;
`endif
      psel = (ph == P_TRAP) ? 2'd2 : ((ph == P_WB && redirects(w, tk)) ? 2'd1 : 2'd0);
      return {3'(ph), ph == P_FETCH, ph == P_MEM, ph == P_MEM && w[6:2] == 5'b01000,
              ph == P_WB && writes_rd(w), ph == P_WB || ph == P_TRAP, psel,
              ph == P_WB, ph == P_TRAP, (ph == P_TRAP) ? 4'd2 : 4'd0, cnt};
   endfunction

   function automatic logic [47:0] actual_vec();
      return {bus.state, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_we,
              bus.pc_sel, bus.retired, bus.trap, bus.trap_cause, bus.instret};
   endfunction

   // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
   task automatic run_instr(input logic [31:0] w, input bit ill, input bit tk,
                            input int iw, input int dw, output int cyc, output logic [4:0] fin);
      int ph[$];
      bit illegal, is_mem, left, done, last;
      illegal = ill || (w[1:0] != 2'b11);
      is_mem  = (w[6:2] == 5'b00000) || (w[6:2] == 5'b01000);
      for (int i = 0; i <= iw; i++) ph.push_back(P_FETCH);
      ph.push_back(P_DECODE);
      if (illegal) ph.push_back(P_TRAP);
      else begin
         ph.push_back(P_EXEC);
         if (is_mem) for (int i = 0; i <= dw; i++) ph.push_back(P_MEM);
         ph.push_back(P_WB);
      end
      cyc = 0; fin = '0; left = 0; done = 0;
      for (int k = 0; k < ph.size(); k++) begin
         last = (k + 1 == ph.size()) || (ph[k+1] != ph[k]);
         bus.imem_ready   = (ph[k] == P_FETCH) ? last : 1'($urandom);
         bus.imem_rdata   = (ph[k] == P_FETCH && last) ? w : $urandom;
         bus.dmem_ready   = (ph[k] == P_MEM) ? last : 1'($urandom);
         bus.dec_illegal  = (ph[k] == P_FETCH) ? 1'($urandom) : ill;
         bus.branch_taken = tk;
         @(negedge clk);
         if (bus.state != 3'd0) left = 1;
         else if (left) done = 1;
         if (!done) cyc++;
         check($sformatf("seq %h ph%0d", w, ph[k]), {16'h0, actual_vec()},
               {16'h0, expect_vec(ph[k], w, tk)});
         if (ph[k] != P_FETCH) check($sformatf("inst %h ph%0d", w, ph[k]), {32'h0, bus.inst}, {32'h0, w});
         if (ph[k] == P_WB || ph[k] == P_TRAP)
            fin = {bus.rf_we, bus.pc_sel, bus.retired, bus.trap};
         @(posedge clk); #1;
         if (ph[k] == P_WB) exp_cnt++;
      end
      if (!(left && bus.state == 3'd0)) cyc = -1;
   endtask

   int          cyc;
   logic [4:0]  fin;
   logic [4:0]  ops[11];
   logic [31:0] w;
   bit          ill;

   initial begin
      tbl[0]  = '{32'h00500093, 0, 0, 0, 0, 4, 5'b1_00_1_0};   // ADDI x1
      tbl[1]  = '{32'h00002103, 0, 0, 0, 3, 8, 5'b1_00_1_0};   // LW, 3 wait cycles
      tbl[2]  = '{32'h00102023, 0, 0, 0, 0, 5, 5'b0_00_1_0};   // SW
      tbl[3]  = '{32'h00000463, 0, 1, 0, 0, 4, 5'b0_01_1_0};   // BEQ taken
      tbl[4]  = '{32'h00000463, 0, 0, 0, 0, 4, 5'b0_00_1_0};   // BEQ not taken
      tbl[5]  = '{32'h00000073, 1, 0, 0, 0, 3, 5'b0_10_0_1};   // illegal by decoder
      tbl[6]  = '{32'h00000013, 0, 0, 0, 0, 4, 5'b0_00_1_0};   // NOP, rd=x0
      tbl[7]  = '{32'h00000001, 0, 0, 0, 0, 3, 5'b0_10_0_1};   // compressed encoding
      tbl[8]  = '{32'h008000EF, 0, 0, 0, 0, 4, 5'b1_01_1_0};   // JAL x1
      tbl[9]  = '{32'h0000000F, 0, 0, 0, 0, 4, 5'b0_00_1_0};   // FENCE
      tbl[10] = '{32'h00500093, 0, 0, 2, 0, 6, 5'b1_00_1_0};   // ADDI, 2 fetch waits
      tbl[11] = '{32'h000122B7, 0, 0, 0, 0, 4, 5'b1_00_1_0};   // LUI x5
      tbl[12] = '{32'h00008067, 0, 0, 0, 0, 4, 5'b0_01_1_0};   // JALR x0

      reset = 1'b1;
      bus.imem_ready = 0; bus.imem_rdata = 0; bus.dec_illegal = 0;
      bus.branch_taken = 0; bus.dmem_ready = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset outputs", {16'h0, actual_vec()}, {16'h0, expect_vec(P_FETCH, 32'h13, 0)});
      check("reset inst", {32'h0, bus.inst}, 64'h13);
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         run_instr(tbl[i].w, tbl[i].ill, tbl[i].tk, tbl[i].iw, tbl[i].dw, cyc, fin);
         check($sformatf("tbl%0d cycles", i), 64'(cyc), 64'(tbl[i].cyc));
         check($sformatf("tbl%0d final strobes", i), {59'h0, fin}, {59'h0, tbl[i].fin});
      end

      // Reset while a load waits in MEM.
      bus.imem_ready = 1; bus.imem_rdata = 32'h00002103; bus.dmem_ready = 0; bus.dec_illegal = 0;
      @(posedge clk); #1;
      bus.imem_ready = 0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("mid mem state", {60'h0, bus.state, bus.dmem_req}, {60'h0, 3'd3, 1'b1});
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      check("post reset outputs", {16'h0, actual_vec()}, {16'h0, expect_vec(P_FETCH, 32'h13, 0)});
      check("post reset inst", {32'h0, bus.inst}, 64'h13);
      @(posedge clk); #1;
      repeat (3) run_instr(32'h00500093, 0, 0, 0, 0, cyc, fin);
`ifdef CORE_SEQ_INSTRET_EN
      check("instret after 3", {32'h0, bus.instret}, 64'd3);
`else
      check("instret tied", {32'h0, bus.instret}, 64'd0);
`endif

      ops = '{5'b00000, 5'b01000, 5'b01100, 5'b00100, 5'b01101, 5'b00101,
              5'b11011, 5'b11001, 5'b11000, 5'b00011, 5'b11100};
      for (int n = 0; n < 60; n++) begin
         w      = $urandom;
         w[6:2] = ops[$urandom_range(0, 10)];
         w[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         ill    = ($urandom_range(0, 7) == 0);
         run_instr(w, ill, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), cyc, fin);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
